// File: rtl/core_wb_stage_pkg.sv
// Shared write-back types: result select, load size, WB FSM states and the
// MEM/WB pipeline-register record. Also used by the MEM stage and control unit.
package core_pkg;

  localparam int CORE_XLEN = 32;

  typedef enum logic [2:0] {
    WB_ALU  = 3'd0,
    WB_LOAD = 3'd1,
    WB_PC4  = 3'd2,
    WB_CSR  = 3'd3,
    WB_IMM  = 3'd4
  } wb_sel_e;

  typedef enum logic [1:0] {
    D_BYTE = 2'd0,
    D_HALF = 2'd1,
    D_WORD = 2'd2,
    D_RSVD = 2'd3
  } d_size_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FULL      = 2'd1,
    WAIT_LOAD = 2'd2
  } wb_state_e;

  // mem_to_reg is kept raw: encodings 5..7 are legal and fall back to ALU.
  typedef struct packed {
    logic [4:0]           rd;
    logic                 reg_write;
    logic [2:0]           mem_to_reg;
    d_size_e              d_size;
    logic                 d_unsigned;
    logic [1:0]           addr_lsb;
    logic [CORE_XLEN-1:0] alu_result;
    logic [CORE_XLEN-1:0] pc_plus4;
    logic [CORE_XLEN-1:0] csr_rdata;
    logic [CORE_XLEN-1:0] imm;
  } mem_wb_t;

  function automatic logic is_load(input logic [2:0] sel);
    return (sel == WB_LOAD);
  endfunction

endpackage

// File: rtl/core_wb_stage_if.sv
// MEM->WB handshake, data-memory response and register-file write port.
// Signal names are from the WB stage's point of view.
interface core_wb_stage_if #(parameter int XLEN = 32);
  logic            i_mem_valid;
  logic            o_mem_ready;
  logic [4:0]      i_rd;
  logic            i_reg_write;
  logic [2:0]      i_mem_to_reg;
  logic [1:0]      i_d_size;
  logic            i_d_unsigned;
  logic [1:0]      i_addr_lsb;
  logic [XLEN-1:0] i_alu_result;
  logic [XLEN-1:0] i_pc_plus4;
  logic [XLEN-1:0] i_csr_rdata;
  logic [XLEN-1:0] i_imm;
  logic            i_dmem_rvalid;
  logic [XLEN-1:0] i_dmem_rdata;
  logic [4:0]      o_wb_rd;
  logic            o_wb_reg_write;
  logic [XLEN-1:0] o_rd_din;
  logic            o_retire;
  logic [63:0]     o_instret;
  logic            o_load_busy;

  modport master (
    output i_mem_valid, i_rd, i_reg_write, i_mem_to_reg, i_d_size, i_d_unsigned,
           i_addr_lsb, i_alu_result, i_pc_plus4, i_csr_rdata, i_imm,
           i_dmem_rvalid, i_dmem_rdata,
    input  o_mem_ready, o_wb_rd, o_wb_reg_write, o_rd_din, o_retire,
           o_instret, o_load_busy
  );

  modport slave (
    input  i_mem_valid, i_rd, i_reg_write, i_mem_to_reg, i_d_size, i_d_unsigned,
           i_addr_lsb, i_alu_result, i_pc_plus4, i_csr_rdata, i_imm,
           i_dmem_rvalid, i_dmem_rdata,
    output o_mem_ready, o_wb_rd, o_wb_reg_write, o_rd_din, o_retire,
           o_instret, o_load_busy
  );
endinterface

// File: rtl/core_wb_stage_load_aligner.sv
// Combinational load extraction: picks the byte/half lane out of an aligned
// word and sign- or zero-extends it.
module load_aligner
  import core_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  d_size_e     i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_lsb,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the lane and extend according to size and signedness
  always_comb begin
    w_byte = i_rdata[8*i_lsb +: 8];
    w_half = i_lsb[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_size)
      D_BYTE:  o_data = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
      D_HALF:  o_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/core_wb_stage.sv
// Write-back stage: MEM/WB pipeline register, load wait, result select,
// register-file write port and the 64-bit retired-instruction counter.
module core_wb_stage
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic               i_clk,
  input logic               i_rst,
  core_wb_stage_if.slave    bus
);

  wb_state_e       r_state;
  mem_wb_t         r_q;
  logic [63:0]     r_instret;

  mem_wb_t         w_in;
  logic            w_ready;
  logic            w_accept;
  logic            w_retire;
  logic [XLEN-1:0] w_load_data;
  logic [XLEN-1:0] w_result;

  assign w_in = '{
    rd:         bus.i_rd,
    reg_write:  bus.i_reg_write,
    mem_to_reg: bus.i_mem_to_reg,
    d_size:     d_size_e'(bus.i_d_size),
    d_unsigned: bus.i_d_unsigned,
    addr_lsb:   bus.i_addr_lsb,
    alu_result: bus.i_alu_result,
    pc_plus4:   bus.i_pc_plus4,
    csr_rdata:  bus.i_csr_rdata,
    imm:        bus.i_imm
  };

  // A pending load frees the register only in the cycle its data arrives;
  // this keeps back-to-back flow without an extra bubble after a load.
  assign w_ready  = (r_state == WAIT_LOAD) ? bus.i_dmem_rvalid : 1'b1;
  assign w_accept = bus.i_mem_valid && w_ready;
  assign w_retire = (r_state == FULL) || ((r_state == WAIT_LOAD) && bus.i_dmem_rvalid);

  load_aligner u_load_aligner (
    .i_rdata    (bus.i_dmem_rdata),
    .i_size     (r_q.d_size),
    .i_unsigned (r_q.d_unsigned),
    .i_lsb      (r_q.addr_lsb),
    .o_data     (w_load_data)
  );

  // Final result select; unused encodings fall back to the ALU result
  always_comb begin
    case (r_q.mem_to_reg)
      WB_LOAD: w_result = w_load_data;
      WB_PC4:  w_result = r_q.pc_plus4;
      WB_CSR:  w_result = r_q.csr_rdata;
      WB_IMM:  w_result = r_q.imm;
      default: w_result = r_q.alu_result;
    endcase
  end

  // FSM, pipeline register and retired-instruction counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_q       <= '0;
      r_instret <= 64'd0;
    end else begin
      if (w_retire) begin
        r_instret <= r_instret + 64'd1;
      end
      if (w_accept) begin
        r_q     <= w_in;
        r_state <= is_load(bus.i_mem_to_reg) ? WAIT_LOAD : FULL;
      end else if (w_retire) begin
        r_state <= IDLE;
      end
    end
  end

  assign bus.o_mem_ready    = w_ready;
  assign bus.o_retire       = w_retire;
  assign bus.o_wb_reg_write = w_retire && r_q.reg_write && (r_q.rd != 5'd0);
  assign bus.o_wb_rd        = r_q.rd;
  assign bus.o_rd_din       = w_result;
  assign bus.o_instret      = r_instret;
  assign bus.o_load_busy    = (r_state == WAIT_LOAD);

endmodule

// File: tb/tb_core_wb_stage.sv
// Directed bench for core_wb_stage: a table of single-instruction vectors
// plus hand-written sequences for load wait, back-to-back, reset and wrap.
module tb_core_wb_stage;
  import core_pkg::*;

  logic i_clk;
  logic i_rst;
  core_wb_stage_if #(.XLEN(32)) bus ();

  core_wb_stage #(.XLEN(32)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [2:0]  sel;
    logic [4:0]  rd;
    logic        we_in;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  lsb;
    logic [31:0] rdata;
    logic        exp_we;
    logic [31:0] exp_din;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_instret = 64'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.i_mem_valid   = 1'b0;
    bus.i_rd          = 5'd0;
    bus.i_reg_write   = 1'b0;
    bus.i_mem_to_reg  = 3'd0;
    bus.i_d_size      = 2'd0;
    bus.i_d_unsigned  = 1'b0;
    bus.i_addr_lsb    = 2'd0;
    bus.i_alu_result  = 32'h0000_1234;
    bus.i_pc_plus4    = 32'h2222_0000;
    bus.i_csr_rdata   = 32'h3333_0000;
    bus.i_imm         = 32'h4444_0000;
    bus.i_dmem_rvalid = 1'b0;
    bus.i_dmem_rdata  = 32'h0;
  endtask

  task automatic drive_instr(input logic [2:0] sel, input logic [4:0] rd, input logic we,
                             input logic [1:0] size, input logic uns, input logic [1:0] lsb);
    bus.i_mem_valid  = 1'b1;
    bus.i_mem_to_reg = sel;
    bus.i_rd         = rd;
    bus.i_reg_write  = we;
    bus.i_d_size     = size;
    bus.i_d_unsigned = uns;
    bus.i_addr_lsb   = lsb;
  endtask

  task automatic apply_vec(input vec_t v);
    @(negedge i_clk);
    drive_instr(v.sel, v.rd, v.we_in, v.size, v.uns, v.lsb);
    @(posedge i_clk);
    #1;
    bus.i_mem_valid = 1'b0;
    if (v.sel == 3'd1) begin
      bus.i_dmem_rvalid = 1'b1;
      bus.i_dmem_rdata  = v.rdata;
    end
    #1;
    chk("vec_retire", {63'd0, bus.o_retire}, 64'd1);
    chk("vec_we", {63'd0, bus.o_wb_reg_write}, {63'd0, v.exp_we});
    if (v.exp_we) begin
      chk("vec_rd", {59'd0, bus.o_wb_rd}, {59'd0, v.rd});
      chk("vec_din", {32'd0, bus.o_rd_din}, {32'd0, v.exp_din});
    end
    exp_instret = exp_instret + 64'd1;
    @(posedge i_clk);
    #1;
    bus.i_dmem_rvalid = 1'b0;
    chk("vec_instret", bus.o_instret, exp_instret);
    chk("vec_idle_retire", {63'd0, bus.o_retire}, 64'd0);
  endtask

  initial begin
    //           sel  rd     we    size  uns   lsb    rdata          exp_we exp_din
    vecs[0]  = '{3'd0, 5'd5,  1'b1, 2'd0, 1'b0, 2'd0, 32'h0,          1'b1, 32'h0000_1234};
    vecs[1]  = '{3'd1, 5'd6,  1'b1, 2'd0, 1'b0, 2'd3, 32'h80AA_BBCC,  1'b1, 32'hFFFF_FF80};
    vecs[2]  = '{3'd1, 5'd6,  1'b1, 2'd0, 1'b1, 2'd3, 32'h80AA_BBCC,  1'b1, 32'h0000_0080};
    vecs[3]  = '{3'd1, 5'd7,  1'b1, 2'd1, 1'b1, 2'd2, 32'h80AA_BBCC,  1'b1, 32'h0000_80AA};
    vecs[4]  = '{3'd1, 5'd7,  1'b1, 2'd1, 1'b0, 2'd2, 32'h80AA_BBCC,  1'b1, 32'hFFFF_80AA};
    vecs[5]  = '{3'd1, 5'd8,  1'b1, 2'd1, 1'b0, 2'd1, 32'h80AA_BBCC,  1'b1, 32'hFFFF_BBCC};
    vecs[6]  = '{3'd1, 5'd8,  1'b1, 2'd0, 1'b0, 2'd1, 32'h80AA_BBCC,  1'b1, 32'hFFFF_FFBB};
    vecs[7]  = '{3'd1, 5'd9,  1'b1, 2'd2, 1'b0, 2'd3, 32'h80AA_BBCC,  1'b1, 32'h80AA_BBCC};
    vecs[8]  = '{3'd1, 5'd9,  1'b1, 2'd3, 1'b1, 2'd2, 32'h80AA_BBCC,  1'b1, 32'h80AA_BBCC};
    vecs[9]  = '{3'd1, 5'd10, 1'b1, 2'd0, 1'b0, 2'd0, 32'h0000_007F,  1'b1, 32'h0000_007F};
    vecs[10] = '{3'd1, 5'd10, 1'b1, 2'd1, 1'b0, 2'd0, 32'h1234_7FFF,  1'b1, 32'h0000_7FFF};
    vecs[11] = '{3'd3, 5'd11, 1'b1, 2'd0, 1'b0, 2'd0, 32'h0,          1'b1, 32'h3333_0000};
    vecs[12] = '{3'd2, 5'd12, 1'b1, 2'd0, 1'b0, 2'd0, 32'h0,          1'b1, 32'h2222_0000};
    vecs[13] = '{3'd4, 5'd13, 1'b1, 2'd0, 1'b0, 2'd0, 32'h0,          1'b1, 32'h4444_0000};
    vecs[14] = '{3'd5, 5'd14, 1'b1, 2'd0, 1'b0, 2'd0, 32'h0,          1'b1, 32'h0000_1234};
    vecs[15] = '{3'd7, 5'd15, 1'b1, 2'd0, 1'b0, 2'd0, 32'h0,          1'b1, 32'h0000_1234};
    vecs[16] = '{3'd0, 5'd0,  1'b1, 2'd0, 1'b0, 2'd0, 32'h0,          1'b0, 32'h0};
    vecs[17] = '{3'd0, 5'd3,  1'b0, 2'd0, 1'b0, 2'd0, 32'h0,          1'b0, 32'h0};

    drive_idle();
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_ready", {63'd0, bus.o_mem_ready}, 64'd1);
    chk("rst_retire", {63'd0, bus.o_retire}, 64'd0);
    chk("rst_we", {63'd0, bus.o_wb_reg_write}, 64'd0);
    chk("rst_busy", {63'd0, bus.o_load_busy}, 64'd0);
    chk("rst_rd", {59'd0, bus.o_wb_rd}, 64'd0);
    chk("rst_din", {32'd0, bus.o_rd_din}, 64'd0);
    chk("rst_instret", bus.o_instret, 64'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    for (int i = 0; i < NV; i++) apply_vec(vecs[i]);

    // Load with data arriving three cycles late: upstream must be stalled
    @(negedge i_clk);
    drive_instr(3'd1, 5'd20, 1'b1, 2'd0, 1'b0, 2'd3);
    @(posedge i_clk);
    #1;
    bus.i_mem_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("wait_ready", {63'd0, bus.o_mem_ready}, 64'd0);
      chk("wait_busy", {63'd0, bus.o_load_busy}, 64'd1);
      chk("wait_retire", {63'd0, bus.o_retire}, 64'd0);
      @(posedge i_clk);
      #1;
    end
    bus.i_dmem_rvalid = 1'b1;
    bus.i_dmem_rdata  = 32'h80AA_BBCC;
    #1;
    chk("late_ready", {63'd0, bus.o_mem_ready}, 64'd1);
    chk("late_we", {63'd0, bus.o_wb_reg_write}, 64'd1);
    chk("late_rd", {59'd0, bus.o_wb_rd}, 64'd20);
    chk("late_din", {32'd0, bus.o_rd_din}, 64'hFFFF_FF80);
    exp_instret = exp_instret + 64'd1;
    @(posedge i_clk);
    #1;
    bus.i_dmem_rvalid = 1'b0;
    chk("late_instret", bus.o_instret, exp_instret);
    chk("late_busy_clr", {63'd0, bus.o_load_busy}, 64'd0);

    // WB_PC4 followed immediately by WB_IMM: writes in consecutive cycles
    @(negedge i_clk);
    bus.i_pc_plus4 = 32'h0000_0100;
    drive_instr(3'd2, 5'd1, 1'b1, 2'd0, 1'b0, 2'd0);
    @(posedge i_clk);
    #1;
    bus.i_imm = 32'hABCD_E000;
    drive_instr(3'd4, 5'd2, 1'b1, 2'd0, 1'b0, 2'd0);
    #1;
    chk("b2b_ready", {63'd0, bus.o_mem_ready}, 64'd1);
    chk("b2b_we0", {63'd0, bus.o_wb_reg_write}, 64'd1);
    chk("b2b_rd0", {59'd0, bus.o_wb_rd}, 64'd1);
    chk("b2b_din0", {32'd0, bus.o_rd_din}, 64'h0000_0100);
    @(posedge i_clk);
    #1;
    bus.i_mem_valid = 1'b0;
    #1;
    chk("b2b_we1", {63'd0, bus.o_wb_reg_write}, 64'd1);
    chk("b2b_rd1", {59'd0, bus.o_wb_rd}, 64'd2);
    chk("b2b_din1", {32'd0, bus.o_rd_din}, 64'hABCD_E000);
    chk("b2b_instret1", bus.o_instret, exp_instret + 64'd1);
    @(posedge i_clk);
    #1;
    exp_instret = exp_instret + 64'd2;
    chk("b2b_instret2", bus.o_instret, exp_instret);
    chk("b2b_retire_off", {63'd0, bus.o_retire}, 64'd0);
    drive_idle();

    // A stray response while idle must not retire anything
    @(negedge i_clk);
    bus.i_dmem_rvalid = 1'b1;
    #1;
    chk("stray_retire", {63'd0, bus.o_retire}, 64'd0);
    @(posedge i_clk);
    #1;
    bus.i_dmem_rvalid = 1'b0;
    chk("stray_instret", bus.o_instret, exp_instret);

    // Reset in the middle of a pending load, then a late response
    @(negedge i_clk);
    drive_instr(3'd1, 5'd9, 1'b1, 2'd2, 1'b0, 2'd0);
    @(posedge i_clk);
    #1;
    bus.i_mem_valid = 1'b0;
    #1;
    chk("pre_rst_busy", {63'd0, bus.o_load_busy}, 64'd1);
    i_rst = 1'b1;
    #1;
    chk("mid_rst_ready", {63'd0, bus.o_mem_ready}, 64'd1);
    chk("mid_rst_busy", {63'd0, bus.o_load_busy}, 64'd0);
    chk("mid_rst_instret", bus.o_instret, 64'd0);
    chk("mid_rst_din", {32'd0, bus.o_rd_din}, 64'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    exp_instret = 64'd0;
    bus.i_dmem_rvalid = 1'b1;
    bus.i_dmem_rdata  = 32'hDEAD_BEEF;
    #1;
    chk("post_rst_retire", {63'd0, bus.o_retire}, 64'd0);
    chk("post_rst_we", {63'd0, bus.o_wb_reg_write}, 64'd0);
    chk("post_rst_ready", {63'd0, bus.o_mem_ready}, 64'd1);
    @(posedge i_clk);
    #1;
    bus.i_dmem_rvalid = 1'b0;
    chk("post_rst_instret", bus.o_instret, 64'd0);

    // Counter wrap from all-ones to zero
    @(negedge i_clk);
    force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.r_instret;
    #1;
    chk("wrap_preload", bus.o_instret, 64'hFFFF_FFFF_FFFF_FFFF);
    exp_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    apply_vec(vecs[0]);
    chk("wrap_zero", bus.o_instret, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got no completion, expected finish");
    $fatal(1);
  end

endmodule
